// File: rtl/core_btb_pkg.sv
// Shared definitions for the BTB controller slice: geometry, entry type
// encodings and the controller state encoding.
package core_btb_pkg;

    localparam int BTB_DEPTH = 64;
    localparam int BTB_IDX_W = 6;

    typedef enum logic [1:0] {
        TYPE_NONE = 2'b00,
        TYPE_BR   = 2'b01,
        TYPE_J    = 2'b10,
        TYPE_JR   = 2'b11
    } btb_type_e;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/core_btb_upd_arb.sv
// Update arbiter for the BTB write port: fixed priority EX over ID, plus a
// defer counter that forces a steal from fetch after MAX_DEFER busy cycles.
module core_btb_upd_arb
    import core_btb_pkg::*;
#(
    parameter int MAX_DEFER = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        fetch_req,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic [1:0]  ex_type,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_target,
    input  logic [1:0]  id_type,
    output logic        grant,
    output logic        sel_id,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_target,
    output logic [1:0]  upd_type
);

    localparam logic [3:0] MAX_DEFER_C = 4'(MAX_DEFER);

    logic       pending;
    logic [3:0] defer_cnt;

    assign pending = ex_valid | id_valid;
    assign grant   = run && pending && (!fetch_req || defer_cnt == MAX_DEFER_C);
    // EX wins whenever it is valid; ID is selected only when EX is idle.
    assign sel_id  = !ex_valid;

    // Payload mux for the selected requester.
    always_comb begin
        upd_pc     = ex_pc;
        upd_target = ex_target;
        upd_type   = ex_type;
        if (sel_id) begin
            upd_pc     = id_pc;
            upd_target = id_target;
            upd_type   = id_type;
        end
    end

    // Count fetch-busy cycles a pending update has waited; cleared on grant or idle.
    always_ff @(posedge clk) begin
        if (!rst || !run) begin
            defer_cnt <= '0;
        end else if (grant || !pending) begin
            defer_cnt <= '0;
        end else if (defer_cnt != MAX_DEFER_C) begin
            defer_cnt <= defer_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/core_btb_ctrl.sv
// BTB index/write port controller: clear sweep after reset or flush, then
// time-shares the port between fetch lookups and EX/ID updates.
// Optional build macro CORE_BTB_CTRL_STATS_EN adds grant/steal counters.
module core_btb_ctrl
    import core_btb_pkg::*;
#(
    parameter int          BTB_DEPTH   = core_btb_pkg::BTB_DEPTH,
    parameter int          MAX_DEFER   = 4,
    parameter logic [23:0] SWEEP_PC_HI = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        fetch_stall,
    input  logic        ex_upd_valid,
    output logic        ex_upd_ready,
    input  logic [31:0] ex_upd_pc,
    input  logic [31:0] ex_upd_target,
    input  logic [1:0]  ex_upd_type,
    input  logic        id_upd_valid,
    output logic        id_upd_ready,
    input  logic [31:0] id_upd_pc,
    input  logic [31:0] id_upd_target,
    input  logic [1:0]  id_upd_type,
    input  logic        flush_req,
`ifdef CORE_BTB_CTRL_STATS_EN
    output logic [15:0] stat_upd_cnt,
    output logic [15:0] stat_steal_cnt,
`endif
    output logic [31:0] btb_pc,
    output logic        update_btb_tag,
    output logic        update_btb_target,
    output logic [31:0] btb_target_in,
    output logic [1:0]  btb_type_in,
    output logic        init_busy
);

    localparam logic [BTB_IDX_W-1:0] LAST_IDX = BTB_IDX_W'(BTB_DEPTH - 1);

    ctrl_state_e          state;
    logic [BTB_IDX_W-1:0] idx;
    logic                 run;
    logic                 grant;
    logic                 sel_id;
    logic [31:0]          upd_pc;
    logic [31:0]          upd_target;
    logic [1:0]           upd_type;
    logic [31:0]          sweep_pc;

    assign run      = rst && (state == ST_RUN);
    assign sweep_pc = {SWEEP_PC_HI, idx, 2'b00};

    core_btb_upd_arb #(
        .MAX_DEFER (MAX_DEFER)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .fetch_req  (fetch_req),
        .ex_valid   (ex_upd_valid),
        .ex_pc      (ex_upd_pc),
        .ex_target  (ex_upd_target),
        .ex_type    (ex_upd_type),
        .id_valid   (id_upd_valid),
        .id_pc      (id_upd_pc),
        .id_target  (id_upd_target),
        .id_type    (id_upd_type),
        .grant      (grant),
        .sel_id     (sel_id),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_type   (upd_type)
    );

    assign ex_upd_ready = grant && !sel_id;
    assign id_upd_ready = grant && sel_id;

    // SWEEP/RUN sequencing; a flush takes effect after any same-cycle grant lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_SWEEP;
            idx   <= '0;
        end else begin
            case (state)
                ST_SWEEP: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= ST_RUN;
                        idx   <= '0;
                    end
                end
                default: begin
                    if (flush_req) begin
                        state <= ST_SWEEP;
                        idx   <= '0;
                    end
                end
            endcase
        end
    end

    // Port mux: sweep write, update write, or fetch lookup.
    always_comb begin
        btb_pc            = fetch_pc;
        update_btb_tag    = 1'b0;
        update_btb_target = 1'b0;
        btb_target_in     = '0;
        btb_type_in       = TYPE_NONE;
        fetch_stall       = 1'b0;
        init_busy         = 1'b0;
        if (!rst) begin
            btb_pc      = sweep_pc;
            fetch_stall = 1'b1;
            init_busy   = 1'b1;
        end else if (state == ST_SWEEP) begin
            btb_pc            = sweep_pc;
            update_btb_tag    = 1'b1;
            update_btb_target = 1'b1;
            fetch_stall       = fetch_req;
            init_busy         = 1'b1;
        end else if (grant) begin
            btb_pc            = upd_pc;
            update_btb_tag    = 1'b1;
            update_btb_target = 1'b1;
            btb_target_in     = upd_target;
            btb_type_in       = upd_type;
            fetch_stall       = fetch_req;
        end
    end

`ifdef CORE_BTB_CTRL_STATS_EN
    // Saturating grant and fetch-steal counters; survive flushes, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_upd_cnt   <= '0;
            stat_steal_cnt <= '0;
        end else if (grant) begin
            if (stat_upd_cnt != 16'hFFFF) begin
                stat_upd_cnt <= stat_upd_cnt + 16'd1;
            end
            if (fetch_req && stat_steal_cnt != 16'hFFFF) begin
                stat_steal_cnt <= stat_steal_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_btb_ctrl.sv
// Directed bench for core_btb_ctrl: vector table for RUN arbitration plus
// hand sequences for reset, sweep, flush and reset-during-sweep.
module tb_core_btb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_stall;
    logic        ex_upd_valid;
    logic        ex_upd_ready;
    logic [31:0] ex_upd_pc;
    logic [31:0] ex_upd_target;
    logic [1:0]  ex_upd_type;
    logic        id_upd_valid;
    logic        id_upd_ready;
    logic [31:0] id_upd_pc;
    logic [31:0] id_upd_target;
    logic [1:0]  id_upd_type;
    logic        flush_req;
    logic [31:0] btb_pc;
    logic        update_btb_tag;
    logic        update_btb_target;
    logic [31:0] btb_target_in;
    logic [1:0]  btb_type_in;
    logic        init_busy;
`ifdef CORE_BTB_CTRL_STATS_EN
    logic [15:0] stat_upd_cnt;
    logic [15:0] stat_steal_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    core_btb_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .fetch_req         (fetch_req),
        .fetch_pc          (fetch_pc),
        .fetch_stall       (fetch_stall),
        .ex_upd_valid      (ex_upd_valid),
        .ex_upd_ready      (ex_upd_ready),
        .ex_upd_pc         (ex_upd_pc),
        .ex_upd_target     (ex_upd_target),
        .ex_upd_type       (ex_upd_type),
        .id_upd_valid      (id_upd_valid),
        .id_upd_ready      (id_upd_ready),
        .id_upd_pc         (id_upd_pc),
        .id_upd_target     (id_upd_target),
        .id_upd_type       (id_upd_type),
        .flush_req         (flush_req),
`ifdef CORE_BTB_CTRL_STATS_EN
        .stat_upd_cnt      (stat_upd_cnt),
        .stat_steal_cnt    (stat_steal_cnt),
`endif
        .btb_pc            (btb_pc),
        .update_btb_tag    (update_btb_tag),
        .update_btb_target (update_btb_target),
        .btb_target_in     (btb_target_in),
        .btb_type_in       (btb_type_in),
        .init_busy         (init_busy)
    );

    typedef struct {
        logic        fr;
        logic [31:0] fpc;
        logic        exv;
        logic [31:0] expc;
        logic [31:0] extg;
        logic [1:0]  exty;
        logic        idv;
        logic [31:0] idpc;
        logic [31:0] idtg;
        logic [1:0]  idty;
        logic        e_stall;
        logic        e_exr;
        logic        e_idr;
        logic        e_we;
        logic [31:0] e_pc;
        logic [31:0] e_tg;
        logic [1:0]  e_ty;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fr, input logic [31:0] fpc,
                                input logic exv, input logic [31:0] expc, input logic [31:0] extg, input logic [1:0] exty,
                                input logic idv, input logic [31:0] idpc, input logic [31:0] idtg, input logic [1:0] idty,
                                input logic e_stall, input logic e_exr, input logic e_idr, input logic e_we,
                                input logic [31:0] e_pc, input logic [31:0] e_tg, input logic [1:0] e_ty);
        vec_t v;
        v.fr = fr; v.fpc = fpc;
        v.exv = exv; v.expc = expc; v.extg = extg; v.exty = exty;
        v.idv = idv; v.idpc = idpc; v.idtg = idtg; v.idty = idty;
        v.e_stall = e_stall; v.e_exr = e_exr; v.e_idr = e_idr; v.e_we = e_we;
        v.e_pc = e_pc; v.e_tg = e_tg; v.e_ty = e_ty;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"}, 32'(fetch_stall), 32'd1);
        chk({tag, "_busy"}, 32'(init_busy), 32'd1);
        chk({tag, "_we"}, {30'd0, update_btb_tag, update_btb_target}, 32'd0);
        chk({tag, "_rdy"}, {30'd0, ex_upd_ready, id_upd_ready}, 32'd0);
    endtask

    // Called at negedge+1 of sweep cycle 0; leaves off at negedge+1 of cycle 63.
    task automatic check_sweep(input string tag);
        for (int i = 0; i < 64; i++) begin
            if (i != 0) begin
                @(negedge clk);
                #1;
            end
            chk($sformatf("%s_busy%0d", tag, i), 32'(init_busy), 32'd1);
            chk($sformatf("%s_pc%0d", tag, i), btb_pc, 32'(i) << 2);
            chk($sformatf("%s_we%0d", tag, i), {30'd0, update_btb_tag, update_btb_target}, 32'd3);
            chk($sformatf("%s_wdata%0d", tag, i), btb_target_in | 32'(btb_type_in), 32'd0);
            chk($sformatf("%s_stall%0d", tag, i), 32'(fetch_stall), 32'(fetch_req));
            chk($sformatf("%s_rdy%0d", tag, i), {30'd0, ex_upd_ready, id_upd_ready}, 32'd0);
        end
    endtask

    initial begin
        // fr fpc | ex v/pc/tg/ty | id v/pc/tg/ty | stall exr idr we pc tg ty
        tbl[0]  = mk(1, 32'h100,  0, 0, 0, 0, 0, 0, 0, 0,                                   0, 0, 0, 0, 32'h100,  0, 0);
        tbl[1]  = mk(0, 32'h104,  1, 32'h1040, 32'h2000, 1, 0, 0, 0, 0,                     0, 1, 0, 1, 32'h1040, 32'h2000, 1);
        tbl[2]  = mk(0, 32'h108,  1, 32'h2220, 32'h3000, 2, 1, 32'h4440, 32'h5000, 3,       0, 1, 0, 1, 32'h2220, 32'h3000, 2);
        tbl[3]  = mk(0, 32'h10C,  0, 0, 0, 0, 1, 32'h4440, 32'h5000, 3,                     0, 0, 1, 1, 32'h4440, 32'h5000, 3);
        for (int k = 4; k <= 7; k++)
            tbl[k] = mk(1, 32'h8000, 0, 0, 0, 0, 1, 32'h6600, 32'h7000, 2,                   0, 0, 0, 0, 32'h8000, 0, 0);
        tbl[8]  = mk(1, 32'h8000, 0, 0, 0, 0, 1, 32'h6600, 32'h7000, 2,                     1, 0, 1, 1, 32'h6600, 32'h7000, 2);
        tbl[9]  = mk(1, 32'h8004, 0, 0, 0, 0, 0, 0, 0, 0,                                   0, 0, 0, 0, 32'h8004, 0, 0);
        tbl[10] = mk(1, 32'h8008, 1, 32'h9900, 32'hA000, 1, 0, 0, 0, 0,                     0, 0, 0, 0, 32'h8008, 0, 0);
        tbl[11] = mk(1, 32'h800C, 0, 0, 0, 0, 0, 0, 0, 0,                                   0, 0, 0, 0, 32'h800C, 0, 0);
        for (int k = 12; k <= 15; k++)
            tbl[k] = mk(1, 32'h8010, 1, 32'h9900, 32'hA000, 1, 0, 0, 0, 0,                   0, 0, 0, 0, 32'h8010, 0, 0);
        tbl[16] = mk(1, 32'h8010, 1, 32'h9900, 32'hA000, 1, 0, 0, 0, 0,                     1, 1, 0, 1, 32'h9900, 32'hA000, 1);

        rst = 1'b0; fetch_req = 1'b1; fetch_pc = 32'h0; flush_req = 1'b0;
        ex_upd_valid = 1'b1; ex_upd_pc = 32'h1234; ex_upd_target = 32'h5678; ex_upd_type = 2'b01;
        id_upd_valid = 1'b1; id_upd_pc = 32'h0; id_upd_target = 32'h0; id_upd_type = 2'b00;

        // Reset held with requests valid: nothing may be written or acknowledged.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check_reset_outputs($sformatf("rst%0d", c));
        end
`ifdef CORE_BTB_CTRL_STATS_EN
        chk("stat_upd_rst", 32'(stat_upd_cnt), 32'd0);
        chk("stat_steal_rst", 32'(stat_steal_cnt), 32'd0);
`endif

        // Release reset: 64 sweep cycles then RUN.
        @(negedge clk);
        ex_upd_valid = 1'b0; id_upd_valid = 1'b0; rst = 1'b1;
        #1;
        check_sweep("sw0");
        @(negedge clk);
        fetch_pc = 32'h40;
        #1;
        chk("sw0_end_busy", 32'(init_busy), 32'd0);
        chk("sw0_end_stall", 32'(fetch_stall), 32'd0);
        chk("sw0_end_pc", btb_pc, 32'h40);

        // RUN arbitration vectors.
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            fetch_req = tbl[v].fr; fetch_pc = tbl[v].fpc;
            ex_upd_valid = tbl[v].exv; ex_upd_pc = tbl[v].expc; ex_upd_target = tbl[v].extg; ex_upd_type = tbl[v].exty;
            id_upd_valid = tbl[v].idv; id_upd_pc = tbl[v].idpc; id_upd_target = tbl[v].idtg; id_upd_type = tbl[v].idty;
            #1;
            chk($sformatf("v%0d_stall", v), 32'(fetch_stall), 32'(tbl[v].e_stall));
            chk($sformatf("v%0d_exr", v), 32'(ex_upd_ready), 32'(tbl[v].e_exr));
            chk($sformatf("v%0d_idr", v), 32'(id_upd_ready), 32'(tbl[v].e_idr));
            chk($sformatf("v%0d_we", v), {30'd0, update_btb_tag, update_btb_target}, tbl[v].e_we ? 32'd3 : 32'd0);
            chk($sformatf("v%0d_pc", v), btb_pc, tbl[v].e_pc);
            if (tbl[v].e_we) begin
                chk($sformatf("v%0d_tg", v), btb_target_in, tbl[v].e_tg);
                chk($sformatf("v%0d_ty", v), 32'(btb_type_in), 32'(tbl[v].e_ty));
            end
        end
`ifdef CORE_BTB_CTRL_STATS_EN
        @(negedge clk);
        ex_upd_valid = 1'b0; id_upd_valid = 1'b0;
        #1;
        chk("stat_upd_tbl", 32'(stat_upd_cnt), 32'd5);
        chk("stat_steal_tbl", 32'(stat_steal_cnt), 32'd2);
`endif

        // Flush coincident with an EX grant; ID stays pending across the sweep.
        @(negedge clk);
        fetch_req = 1'b0; flush_req = 1'b1;
        ex_upd_valid = 1'b1; ex_upd_pc = 32'hC040; ex_upd_target = 32'hD000; ex_upd_type = 2'b01;
        id_upd_valid = 1'b1; id_upd_pc = 32'hE040; id_upd_target = 32'hF000; id_upd_type = 2'b11;
        #1;
        chk("fl_exr", 32'(ex_upd_ready), 32'd1);
        chk("fl_idr", 32'(id_upd_ready), 32'd0);
        chk("fl_pc", btb_pc, 32'hC040);
        chk("fl_we", {30'd0, update_btb_tag, update_btb_target}, 32'd3);
        @(negedge clk);
        flush_req = 1'b0; ex_upd_valid = 1'b0;
        #1;
        check_sweep("sw1");
        @(negedge clk);
        #1;
        chk("fl_id_busy", 32'(init_busy), 32'd0);
        chk("fl_id_rdy", 32'(id_upd_ready), 32'd1);
        chk("fl_id_pc", btb_pc, 32'hE040);
        chk("fl_id_tg", btb_target_in, 32'hF000);
        chk("fl_id_ty", 32'(btb_type_in), 32'd3);

        // Reset at sweep index 30 restarts the sweep from index 0.
        @(negedge clk);
        id_upd_valid = 1'b0; fetch_req = 1'b1; flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        for (int c = 0; c < 30; c++) @(negedge clk);
        #1;
        chk("mid_pc30", btb_pc, 32'h78);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("mid_rst");
`ifdef CORE_BTB_CTRL_STATS_EN
        chk("stat_upd_rst2", 32'(stat_upd_cnt), 32'd0);
        chk("stat_steal_rst2", 32'(stat_steal_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_sweep("sw2");
        @(negedge clk);
        #1;
        chk("sw2_end_busy", 32'(init_busy), 32'd0);
        chk("sw2_end_stall", 32'(fetch_stall), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/core_btb_ctrl.md
Name: core_btb_ctrl

Overview:
Controller that owns the single index/write port of core_btb. It sequences a post-reset and on-demand clear sweep over all BTB entries, and arbitrates BTB update requests from two requesters: EX (branch resolve) and ID (jump resolve). It also time-shares the shared pc index with fetch lookups and raises fetch_stall whenever it steals the port.

Parameters:
BTB_DEPTH, 64, number of BTB entries; index is pc[7:2].
MAX_DEFER, 4, max consecutive fetch-busy cycles a pending update may wait before forcing a steal (1..15).
SWEEP_PC_HI, 24'h000000, pc[31:8] driven during sweep writes.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
fetch_req  in  1  fetch wants a BTB lookup this cycle
fetch_pc  in  32  fetch lookup pc
fetch_stall  out  1  fetch lookup not serviced this cycle
ex_upd_valid  in  1  EX update request
ex_upd_ready  out  1  EX update written this cycle
ex_upd_pc  in  32  branch pc
ex_upd_target  in  32  resolved target
ex_upd_type  in  2  branch type
id_upd_valid / id_upd_ready / id_upd_pc / id_upd_target / id_upd_type  same as ex_*, for ID jumps
flush_req  in  1  one-cycle pulse: clear the entire BTB
btb_pc  out  32  pc driven to core_btb
update_btb_tag  out  1  tag write enable
update_btb_target  out  1  target/type write enable
btb_target_in  out  32  write target
btb_type_in  out  2  write type
init_busy  out  1  sweep in progress

Behaviour:
- States: SWEEP, RUN. Reset (rst=0 at a clk edge) enters SWEEP with idx=0 and defer_cnt=0.
- Outputs during reset: every write enable and ready is 0, fetch_stall=1, init_busy=1.
- SWEEP:
  - Each cycle drive btb_pc={SWEEP_PC_HI, idx, 2'b00}, both write enables=1, btb_target_in=0, btb_type_in=2'b00 (TYPE_NONE; consumers treat it as no prediction).
  - idx increments each cycle. After idx=BTB_DEPTH-1 is written, go to RUN on the next cycle. A sweep takes exactly BTB_DEPTH cycles.
  - fetch_stall=fetch_req; both readys=0; flush_req is ignored.
- RUN, arbitration:
  - Pending update = ex_upd_valid|id_upd_valid.
  - Selection is fixed priority, EX over ID.
  - Grant when (pending && (!fetch_req || defer_cnt==MAX_DEFER)).
- RUN, grant cycle:
  - btb_pc=selected pc; both write enables=1; btb_target_in=selected target; btb_type_in=selected type.
  - Only the selected requester's ready=1.
  - fetch_stall=fetch_req.
  - defer_cnt<=0.
- RUN, no-grant cycle:
  - btb_pc=fetch_pc; write enables=0; fetch_stall=0.
  - defer_cnt<=defer_cnt+1 if pending, else 0. Saturates at MAX_DEFER.
- Handshake:
  - Transfer occurs when valid&&ready, in the same cycle. The write lands at that clk edge.
  - Requesters hold valid and data stable until ready. Ready never asserts without valid.
  - Outputs are combinational from state and inputs; zero-cycle latency from grant to write.
- flush_req in RUN: any grant in that same cycle still completes; SWEEP starts at idx=0 on the next cycle. Requests remaining pending are held (ready=0) until RUN.
- Simultaneous EX and ID valid: EX granted first; ID waits. Each grant needs its own eligible cycle, and defer_cnt restarts at 0 after the EX grant.
- Reset mid-sweep or mid-RUN: restart SWEEP from idx=0. No partial state survives.

Optional Feature:
CORE_BTB_CTRL_STATS_EN
- Defined: adds outputs stat_upd_cnt[15:0] (grants) and stat_steal_cnt[15:0] (grant cycles with fetch_req=1).
  - Both counters saturate at 16'hFFFF and reset to 0.
  - flush_req does not clear them.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package core_btb_pkg: BTB_DEPTH, BTB_IDX_W=6, BTB type encodings (TYPE_NONE=2'b00, TYPE_BR, TYPE_J, TYPE_JR), state encoding.
- One sub-module, core_btb_upd_arb: two-requester fixed-priority select plus defer_cnt. It outputs grant, sel and payload mux.
- Top level keeps the SWEEP/RUN FSM, idx counter and port mux.

Test Plan:
- Reset release, fetch_req=1 constant → init_busy=1 and fetch_stall=1 for exactly 64 cycles. btb_pc steps 0x00..0xFC; init_busy=0 on cycle 65.
- RUN, fetch_req=0, EX valid pc=0x0000_1040, target=0x0000_2000, type=01 → same-cycle ex_upd_ready=1, btb_pc=0x1040, both enables=1. A subsequent fetch of 0x1040 reads btb_v=1, target 0x2000.
- fetch_req=1 continuously, ID valid, MAX_DEFER=4 → id_upd_ready=1 on the 5th cycle. fetch_stall=1 only in that cycle.
- EX and ID valid together, fetch_req=0 → EX ready in cycle N, ID ready in cycle N+1. No cycle has both readys high.
- flush_req pulse coincident with an EX grant → EX write completes; sweep runs the following 64 cycles. A pending ID request is granted after sweep end.
- rst=0 asserted at sweep idx=30 → after release, sweep restarts at idx=0 and runs a full 64 cycles. With CORE_BTB_CTRL_STATS_EN, counters read 0.
